// File: rtl/read_fmps_test_link.sv
// Receive side of the FMPS test link: checks framing, magic and length of each
// packet, rejects repeated indices within an FA cycle and summarises each cycle.
module read_fmps_test_link #(
  parameter int MAGIC_WIDTH     = 16,
  parameter int MAGIC_START_BIT = 16,
  parameter int INDEX_WIDTH     = 5,
  parameter int INDEX_START_BIT = 10,
  parameter int NUM_DATA_WORDS  = 1
) (
  input  logic                          auroraUserClk,
  input  logic                          auroraReset,
  input  logic                          auroraChannelUp,
  input  logic                          auroraFAstrobe,
  input  logic [31:0]                   FMPS_TEST_AXI_STREAM_RX_tdata,
  input  logic                          FMPS_TEST_AXI_STREAM_RX_tvalid,
  input  logic                          FMPS_TEST_AXI_STREAM_RX_tlast,
  output logic                          FMPS_TEST_AXI_STREAM_RX_tready,
  input  logic [MAGIC_WIDTH-1:0]        expectedHeaderMagic,
  output logic                          statusStrobe,
  output logic [1:0]                    statusCode,
  output logic                          packetStrobe,
  output logic [INDEX_WIDTH-1:0]        packetIndex,
  output logic [32*NUM_DATA_WORDS-1:0]  packetData,
  output logic                          cycleStrobe,
  output logic [2**INDEX_WIDTH-1:0]     cycleIndexMask,
  output logic [INDEX_WIDTH:0]          cyclePacketCount
);

  localparam int MASK_W = 2**INDEX_WIDTH;
  localparam int CNT_W  = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
  localparam logic [CNT_W-1:0]       LAST_WORD = CNT_W'(NUM_DATA_WORDS - 1);
  localparam logic [MASK_W-1:0]      MASK_ONE  = MASK_W'(1);
  localparam logic [INDEX_WIDTH:0]   COUNT_ONE = (INDEX_WIDTH+1)'(1);

  localparam logic [1:0] CODE_OK     = 2'd0;
  localparam logic [1:0] CODE_MAGIC  = 2'd1;
  localparam logic [1:0] CODE_LENGTH = 2'd2;
  localparam logic [1:0] CODE_DUP    = 2'd3;

  typedef enum logic [1:0] {S_HEADER, S_DATA, S_DRAIN} state_t;

  state_t                         r_state;
  state_t                         w_state_next;
  logic [CNT_W-1:0]               r_word_cnt;
  logic [INDEX_WIDTH-1:0]         r_index;
  logic [MASK_W-1:0]              r_mask;
  logic [INDEX_WIDTH:0]           r_count;

  logic                           r_status_strobe;
  logic [1:0]                     r_status_code;
  logic                           r_packet_strobe;
  logic [INDEX_WIDTH-1:0]         r_packet_index;
  logic [32*NUM_DATA_WORDS-1:0]   r_packet_data;
  logic                           r_cycle_strobe;
  logic [MASK_W-1:0]              r_cycle_mask;
  logic [INDEX_WIDTH:0]           r_cycle_count;

  logic                           w_verdict;
  logic [1:0]                     w_code;
  logic                           w_complete;
  logic                           w_load_index;
  logic                           w_cnt_inc;
  logic                           w_dup;
  logic                           w_good;
  logic                           w_data_beat;
  logic [MASK_W-1:0]              w_onehot;
  logic [MAGIC_WIDTH-1:0]         w_magic;
  logic [INDEX_WIDTH-1:0]         w_hdr_index;
  logic [32*NUM_DATA_WORDS-1:0]   w_assembled;

  assign FMPS_TEST_AXI_STREAM_RX_tready = auroraChannelUp;
  assign w_magic     = FMPS_TEST_AXI_STREAM_RX_tdata[MAGIC_START_BIT +: MAGIC_WIDTH];
  assign w_hdr_index = FMPS_TEST_AXI_STREAM_RX_tdata[INDEX_START_BIT +: INDEX_WIDTH];
  assign w_data_beat = auroraChannelUp & FMPS_TEST_AXI_STREAM_RX_tvalid & (r_state == S_DATA);

  always_comb begin
    w_state_next = r_state;
    w_verdict    = 1'b0;
    w_code       = CODE_OK;
    w_complete   = 1'b0;
    w_load_index = 1'b0;
    w_cnt_inc    = 1'b0;
    if (!auroraChannelUp) begin
      // A dropped link abandons any partial packet without a verdict.
      w_state_next = S_HEADER;
    end else if (FMPS_TEST_AXI_STREAM_RX_tvalid) begin
      case (r_state)
        S_HEADER: begin
          if (FMPS_TEST_AXI_STREAM_RX_tlast) begin
            w_verdict = 1'b1;
            w_code    = CODE_LENGTH;
          end else if (w_magic != expectedHeaderMagic) begin
            w_verdict    = 1'b1;
            w_code       = CODE_MAGIC;
            w_state_next = S_DRAIN;
          end else begin
            w_load_index = 1'b1;
            w_state_next = S_DATA;
          end
        end
        S_DATA: begin
          if (r_word_cnt == LAST_WORD) begin
            if (FMPS_TEST_AXI_STREAM_RX_tlast) begin
              w_complete   = 1'b1;
              w_state_next = S_HEADER;
            end else begin
              w_verdict    = 1'b1;
              w_code       = CODE_LENGTH;
              w_state_next = S_DRAIN;
            end
          end else if (FMPS_TEST_AXI_STREAM_RX_tlast) begin
            w_verdict    = 1'b1;
            w_code       = CODE_LENGTH;
            w_state_next = S_HEADER;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        S_DRAIN: begin
          if (FMPS_TEST_AXI_STREAM_RX_tlast) w_state_next = S_HEADER;
        end
        default: w_state_next = S_HEADER;
      endcase
    end
  end

  // A completion on the FA boundary belongs to the new cycle, whose mask starts empty.
  assign w_dup    = w_complete & r_mask[r_index] & ~auroraFAstrobe;
  assign w_good   = w_complete & ~w_dup;
  assign w_onehot = MASK_ONE << r_index;

  generate
    if (NUM_DATA_WORDS > 1) begin : g_stage
      logic [32*(NUM_DATA_WORDS-1)-1:0] r_stage;
      for (genvar gi = 0; gi < NUM_DATA_WORDS-1; gi++) begin : g_slot
        always_ff @(posedge auroraUserClk) begin
          if (w_data_beat && r_word_cnt == CNT_W'(gi))
            r_stage[32*gi +: 32] <= FMPS_TEST_AXI_STREAM_RX_tdata;
        end
      end
      assign w_assembled = {FMPS_TEST_AXI_STREAM_RX_tdata, r_stage};
    end else begin : g_no_stage
      assign w_assembled = FMPS_TEST_AXI_STREAM_RX_tdata;
    end
  endgenerate

  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) r_state <= S_HEADER;
    else             r_state <= w_state_next;
  end

  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      r_word_cnt      <= '0;
      r_index         <= '0;
      r_mask          <= '0;
      r_count         <= '0;
      r_status_strobe <= 1'b0;
      r_status_code   <= CODE_OK;
      r_packet_strobe <= 1'b0;
      r_packet_index  <= '0;
      r_packet_data   <= '0;
      r_cycle_strobe  <= 1'b0;
      r_cycle_mask    <= '0;
      r_cycle_count   <= '0;
    end else begin
      if (w_load_index) begin
        r_index    <= w_hdr_index;
        r_word_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end

      r_status_strobe <= w_verdict | w_complete;
      r_status_code   <= w_complete ? (w_dup ? CODE_DUP : CODE_OK) : w_code;
      r_packet_strobe <= w_good;
      if (w_good) begin
        r_packet_index <= r_index;
        r_packet_data  <= w_assembled;
      end

      r_cycle_strobe <= auroraFAstrobe;
      if (auroraFAstrobe) begin
        r_cycle_mask  <= r_mask;
        r_cycle_count <= r_count;
        r_mask        <= w_good ? w_onehot : '0;
        r_count       <= w_good ? COUNT_ONE : '0;
      end else if (w_good) begin
        r_mask  <= r_mask | w_onehot;
        r_count <= r_count + COUNT_ONE;
      end
    end
  end

  assign statusStrobe     = r_status_strobe;
  assign statusCode       = r_status_code;
  assign packetStrobe     = r_packet_strobe;
  assign packetIndex      = r_packet_index;
  assign packetData       = r_packet_data;
  assign cycleStrobe      = r_cycle_strobe;
  assign cycleIndexMask   = r_cycle_mask;
  assign cyclePacketCount = r_cycle_count;

endmodule
